// File: rtl/pio_hc595_shifter.sv
// pio_hc595_shifter: serialises a parallel PIO value MSB-first onto a 74HC595 (SER/SRCLK/RCLK).
// Define PIO_HC595_OE_EN to add hc_oe_n, which keeps the 595 outputs disabled until the first frame has latched.
module pio_hc595_shifter #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             update_req,
  output logic             busy,
  output logic             hc_ser,
  output logic             hc_srclk,
`ifdef PIO_HC595_OE_EN
  output logic             hc_rclk,
  output logic             hc_oe_n
`else
  output logic             hc_rclk
`endif
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BCW-1:0] BIT_TOP = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] DIV_TOP = DCW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sent_q, sent_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             pending_q, pending_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic             busy_q, ser_q, srclk_q, rclk_q;
  logic             trigger_s, div_done_s;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sent_q    <= {WIDTH{1'b0}};
      shreg_q   <= {WIDTH{1'b0}};
      pending_q <= 1'b1;
      bit_cnt_q <= {BCW{1'b0}};
      div_cnt_q <= {DCW{1'b0}};
    end else begin
      state_q   <= state_d;
      sent_q    <= sent_d;
      shreg_q   <= shreg_d;
      pending_q <= pending_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Next-state logic; an update_req seen while busy is parked in pending for one follow-on frame.
  always_comb begin
    state_d    = state_q;
    sent_d     = sent_q;
    shreg_d    = shreg_q;
    pending_d  = pending_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    trigger_s  = (data_in != sent_q) || pending_q || update_req;
    div_done_s = (div_cnt_q == DIV_TOP);
    case (state_q)
      ST_IDLE: begin
        if (trigger_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        shreg_d   = data_in;
        sent_d    = data_in;
        pending_d = update_req;
        bit_cnt_d = BIT_TOP;
        div_cnt_d = {DCW{1'b0}};
        state_d   = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        pending_d = pending_q | update_req;
        if (div_done_s) begin
          div_cnt_d = {DCW{1'b0}};
          state_d   = ST_SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        pending_d = pending_q | update_req;
        if (div_done_s) begin
          div_cnt_d = {DCW{1'b0}};
          shreg_d   = shreg_q << 1'b1;
          if (bit_cnt_q == {BCW{1'b0}}) begin
            state_d = ST_LATCH;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            state_d   = ST_SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        pending_d = pending_q | update_req;
        if (div_done_s) begin
          div_cnt_d = {DCW{1'b0}};
          state_d   = ST_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pins are loaded from next-state so each one changes on the very edge that enters its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      ser_q   <= 1'b0;
      srclk_q <= 1'b0;
      rclk_q  <= 1'b0;
    end else begin
      busy_q  <= (state_d != ST_IDLE);
      ser_q   <= shreg_d[WIDTH-1];
      srclk_q <= (state_d == ST_SHIFT_HI);
      rclk_q  <= (state_d == ST_LATCH);
    end
  end

  assign busy     = busy_q;
  assign hc_ser   = ser_q;
  assign hc_srclk = srclk_q;
  assign hc_rclk  = rclk_q;

`ifdef PIO_HC595_OE_EN
  logic oe_n_q;

  // Enable the 595 outputs once the first complete frame has been latched; only reset disables them again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oe_n_q <= 1'b1;
    end else if ((state_q == ST_LATCH) && (state_d == ST_IDLE)) begin
      oe_n_q <= 1'b0;
    end else begin
      oe_n_q <= oe_n_q;
    end
  end

  assign hc_oe_n = oe_n_q;
`endif

endmodule

// File: tb/tb_pio_hc595_shifter.sv
// Scoreboard bench for pio_hc595_shifter: a model 74HC595 is driven from the DUT pins and each
// latched byte is popped against the expected queue filled by the directed stimulus.
module tb_pio_hc595_shifter;

`ifdef PIO_HC595_OE_EN
  localparam int TB_DIV = 1;
`else
  localparam int TB_DIV = 4;
`endif
  localparam int W      = 8;
  localparam int FRAME  = 1 + 2 * W * TB_DIV + TB_DIV;
  localparam int C1     = (FRAME * 20) / 69;
  localparam int C2     = (FRAME * 40) / 69;
  localparam int C3     = (FRAME * 30) / 69;
  localparam int U1     = (FRAME * 10) / 69;
  localparam int BUDGET = 4 * FRAME + 20;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         update_req = 1'b0;
  logic [W-1:0] data_in = 8'hFF;
  logic         busy, hc_ser, hc_srclk, hc_rclk;
`ifdef PIO_HC595_OE_EN
  logic         hc_oe_n;
`endif

  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   exp_q[$];

  // monitor / model 595 state
  int           cyc = 0;
  int           frames_started = 0;
  int           busy_len = 0;
  int           rises = 0;
  int           last_rise_cyc = 0;
  int           rclk_start = 0;
  int           ser_age = 0;
  logic [7:0]   model_sr = 8'h00;
  logic [7:0]   model_lat = 8'h00;
  logic         prev_busy = 1'b0, prev_ser = 1'b0, prev_srclk = 1'b0, prev_rclk = 1'b0;
  logic         first_frame = 1'b1;
  logic         oe_early = 1'b0;

  pio_hc595_shifter #(.WIDTH(W), .CLK_DIV(TB_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .update_req (update_req),
    .busy       (busy),
    .hc_ser     (hc_ser),
    .hc_srclk   (hc_srclk),
`ifdef PIO_HC595_OE_EN
    .hc_rclk    (hc_rclk),
    .hc_oe_n    (hc_oe_n)
`else
    .hc_rclk    (hc_rclk)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: samples pins on the falling edge, drives the model 595 and pops the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_busy = 1'b0; prev_ser = 1'b0; prev_srclk = 1'b0; prev_rclk = 1'b0;
        ser_age = 0; first_frame = 1'b1; oe_early = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          frames_started++;
          busy_len = 0;
          rises = 0;
        end
        if (busy) busy_len++;
`ifdef PIO_HC595_OE_EN
        if (first_frame && busy && (hc_oe_n !== 1'b1)) oe_early = 1'b1;
`endif
        if (!busy && prev_busy) begin
          check("busy_length", busy_len, FRAME);
`ifdef PIO_HC595_OE_EN
          if (first_frame) begin
            check("oe_high_during_first_frame", oe_early, 1'b0);
            check("oe_fall_after_first_latch", hc_oe_n, 1'b0);
            first_frame = 1'b0;
          end
`endif
        end
        if (hc_ser != prev_ser) begin
          if (rises > 0) check("ser_hold", (cyc - last_rise_cyc) >= TB_DIV, 1'b1);
          ser_age = 0;
        end else begin
          ser_age++;
        end
        if (hc_srclk && !prev_srclk) begin
          check("ser_setup", ser_age >= TB_DIV, 1'b1);
          model_sr = {model_sr[6:0], hc_ser};
          rises++;
          last_rise_cyc = cyc;
        end
        if (hc_rclk && !prev_rclk) begin
          model_lat = model_sr;
          rclk_start = cyc;
          check("srclk_rises_per_frame", rises, W);
          check("rclk_after_last_srclk", cyc - last_rise_cyc, TB_DIV);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_latch: actual=%0h required=no latch", model_lat);
          end else begin
            check("latched_value", model_lat, exp_q.pop_front());
          end
        end
        if (!hc_rclk && prev_rclk) check("rclk_width", cyc - rclk_start, TB_DIV);
        prev_busy = busy; prev_ser = hc_ser; prev_srclk = hc_srclk; prev_rclk = hc_rclk;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_busy(input string name);
    int t;
    t = 0;
    while (!busy && t < BUDGET) begin step(); t++; end
    check({name, "_frame_start"}, busy, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < BUDGET) begin step(); t++; end
    check({name, "_frame_end"}, busy, 1'b0);
  endtask

  // Directed stimulus; expected latched bytes are pushed as each frame is provoked.
  initial begin
    int fs;
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_ser", hc_ser, 1'b0);
    check("rst_srclk", hc_srclk, 1'b0);
    check("rst_rclk", hc_rclk, 1'b0);
`ifdef PIO_HC595_OE_EN
    check("rst_oe_n", hc_oe_n, 1'b1);
`endif

    // power-up frame with FF
    exp_q.push_back(8'hFF);
    reset = 1'b0;
    step();
    check("busy_cycle1_after_release", busy, 1'b1);
    wait_idle("t1");
    check("t1_model_latch", model_lat, 8'hFF);
    fs = frames_started;
    repeat (30) step();
    check("t1_no_spurious_frame", frames_started - fs, 0);

    // FF -> A5 in IDLE
    data_in = 8'hA5;
    exp_q.push_back(8'hA5);
    wait_busy("t2");
    wait_idle("t2");
    check("t2_model_latch", model_lat, 8'hA5);

    // mid-frame changes: 5A frame completes, then only 0F follows
    fs = frames_started;
    data_in = 8'h5A;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h0F);
    wait_busy("t3a");
    repeat (C1 - 1) step();
    data_in = 8'h3C;
    repeat (C2 - C1) step();
    data_in = 8'h0F;
    wait_idle("t3a");
    wait_busy("t3b");
    wait_idle("t3b");
    repeat (20) step();
    check("t3_frame_count", frames_started - fs, 2);
    check("t3_model_latch", model_lat, 8'h0F);

    // update_req in IDLE, then three pulses during the frame collapse into one extra frame
    fs = frames_started;
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h0F);
    update_req = 1'b1;
    step();
    update_req = 1'b0;
    wait_busy("t4a");
    repeat (3) begin
      repeat (U1) step();
      update_req = 1'b1;
      step();
      update_req = 1'b0;
    end
    wait_idle("t4a");
    wait_busy("t4b");
    wait_idle("t4b");
    repeat (20) step();
    check("t4_frame_count", frames_started - fs, 2);

    // simultaneous data change and update_req in IDLE -> one frame
    fs = frames_started;
    data_in = 8'hC3;
    update_req = 1'b1;
    exp_q.push_back(8'hC3);
    step();
    update_req = 1'b0;
    wait_busy("t5");
    wait_idle("t5");
    repeat (20) step();
    check("t5_frame_count", frames_started - fs, 1);
    check("t5_model_latch", model_lat, 8'hC3);
`ifdef PIO_HC595_OE_EN
    check("oe_stays_low", hc_oe_n, 1'b0);
`endif

    // reset mid-frame: no latch, model keeps C3, full frame with 96 after release
    data_in = 8'h96;
    wait_busy("t6a");
    repeat (C3 - 1) step();
    reset = 1'b1;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_ser", hc_ser, 1'b0);
    check("t6_rst_srclk", hc_srclk, 1'b0);
    check("t6_rst_rclk", hc_rclk, 1'b0);
`ifdef PIO_HC595_OE_EN
    check("t6_rst_oe_n", hc_oe_n, 1'b1);
`endif
    repeat (3) step();
    check("t6_model_holds", model_lat, 8'hC3);
    exp_q.push_back(8'h96);
    reset = 1'b0;
    step();
    check("t6_busy_after_release", busy, 1'b1);
    wait_idle("t6b");
    check("t6_model_latch", model_lat, 8'h96);
    repeat (10) step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
